mips_avalon_arbiter: RTL and testbench
======================================

Name: mips_avalon_arbiter

Overview:
- Two-requester arbiter sharing the CPU's single Avalon memory-mapped master bus between the instruction-fetch path (read-only) and the load/store data path (read/write).
- Sits between the mips_cpu_bus control logic and the external Avalon slave.
- Picks an owner, locks it for the whole waitrequest-stalled transfer, and stalls the loser with a per-port waitrequest.
- Also flags protocol violations and bus hangs.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = data port has fixed priority.
- TIMEOUT_CYCLES, 1024, consecutive stalled cycles before the timeout flag sets; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_read  input  1  fetch read request.
- i_address  input  32  fetch address.
- i_waitrequest  output  1  fetch stall.
- i_readdata  output  32  fetch read data.
- d_read  input  1  data read request.
- d_write  input  1  data write request.
- d_address  input  32  data address.
- d_writedata  input  32  store data.
- d_byteenable  input  4  store/load lane enables.
- d_waitrequest  output  1  data stall.
- d_readdata  output  32  load data.
- address  output  32  Avalon address.
- read  output  1  Avalon read.
- write  output  1  Avalon write.
- writedata  output  32  Avalon write data.
- byteenable  output  4  Avalon byte enables.
- waitrequest  input  1  Avalon slave stall.
- readdata  input  32  Avalon read data.
- grant  output  2  current owner: 00 none, 01 fetch, 10 data.
- protocol_err  output  1  sticky protocol violation flag.
- timeout  output  1  sticky bus hang flag.

Behaviour:
- Reset state, asynchronous on reset low:
  - owner=NONE, last=DATA (so fetch wins the first tie), stall counter=0, protocol_err=0, timeout=0.
  - read=0, write=0, grant=00, i_waitrequest=1, d_waitrequest=1.
- Owner register states:
  - NONE: no transfer in flight.
  - FETCH: fetch transfer locked.
  - DATA: data transfer locked.
- Arbitration in NONE is combinational, so there is zero added latency:
  - Only one requester active: it wins.
  - Both active, ROUND_ROBIN=1: the port not equal to last wins.
  - Both active, ROUND_ROBIN=0: data wins.
  - The winner's signals drive the master bus in the same cycle.
- Transfer completion:
  - A transfer completes in the cycle where the winner/owner is driving and waitrequest=0.
  - On completion: the owner's waitrequest is 0 that cycle, readdata passes through to the owner's *_readdata, last<=owner, owner<=NONE.
  - On the next cycle a new arbitration happens, so back-to-back transfers have no idle cycle.
- Transfer stall:
  - If waitrequest=1 in NONE with a winner, owner<=winner (lock).
  - While locked, only the owner drives the bus; the other port sees waitrequest=1 whatever its request.
- Mux details:
  - Fetch owner: read=i_read, write=0, byteenable=4'b1111, writedata=0.
  - Data owner: d_* pass through directly.
  - *_readdata for a non-owner: 0.
  - Idle (no requests): address=0, byteenable=0, read=0, write=0.
- Requester rule: hold its command stable while its waitrequest=1.
- Owner drops its request while locked:
  - Protocol violation: protocol_err<=1.
  - owner<=NONE next cycle; read and write are 0 from the drop cycle.
- d_read and d_write both 1 when granted:
  - Forward as write only (read=0).
  - protocol_err<=1.
- Stall counter:
  - Increments each cycle owner≠NONE and waitrequest=1; clears on completion or on return to NONE.
  - Saturates at TIMEOUT_CYCLES; reaching it sets timeout<=1 (sticky).
  - Timeout does not abort the transfer.
- protocol_err and timeout clear only on reset.
- Reset asserted mid-transfer: owner is dropped immediately and read/write go to 0 asynchronously. The slave transfer is abandoned; a slave that cannot tolerate this is outside this block's scope.
- grant reflects the registered owner when locked, or the combinational winner in NONE.

Test Plan:
- Single fetch:
  - Stimulus: i_read=1, i_address=BFC00000, waitrequest low, readdata=24020005.
  - Required response: same cycle read=1, address=BFC00000, i_waitrequest=0, i_readdata=24020005, grant=01.
- Contention, round-robin:
  - Stimulus: i_read and d_read held 1 after reset, waitrequest always 0.
  - Required response: grants alternate 01,10,01,10 on consecutive cycles; the loser sees waitrequest=1.
- Locked stall:
  - Stimulus: d_write=1, d_address=00001000, d_writedata=DEADBEEF, d_byteenable=0011, waitrequest high for 3 cycles; i_read raised on cycle 1.
  - Required response: write held with unchanged data for 4 cycles; i_waitrequest=1 throughout; fetch granted on cycle 5.
- Fixed priority:
  - Stimulus: ROUND_ROBIN=0, both ports requesting continuously.
  - Required response: data granted every cycle; fetch starves.
- Protocol errors:
  - Stimulus: d_read=d_write=1.
  - Required response: write=1, read=0, protocol_err=1.
  - Stimulus: separately, owner drops its request while locked.
  - Required response: owner returns to NONE and protocol_err=1.
- Timeout and reset:
  - Stimulus: TIMEOUT_CYCLES=8, waitrequest stuck high.
  - Required response: timeout=1 after 8 stalled cycles with the transfer still driven.
  - Stimulus: reset pulsed low.
  - Required response: read=0, grant=00, timeout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_avalon_arbiter.sv
// rtl/mips_avalon_arbiter.sv - two-port Avalon-MM arbiter (fetch/data) with transfer lock,
// protocol-error and bus-hang detection.
module mips_avalon_arbiter #(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        protocol_err,
  output logic        timeout
);

  // Encoding doubles as the grant output value.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } owner_e;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  owner_e        owner_q, owner_d;
  owner_e        last_q, last_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          perr_q, perr_d;
  logic          tout_q, tout_d;

  owner_e winner, cur;
  logic   i_req, d_req, active, done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      last_q  <= OWN_DATA;
      stall_q <= '0;
      perr_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      perr_q  <= perr_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    i_req  = i_read;
    d_req  = d_read | d_write;
    winner = OWN_NONE;
    if (i_req && d_req) begin
      if (ROUND_ROBIN) winner = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
      else             winner = OWN_DATA;
    end else if (i_req) begin
      winner = OWN_FETCH;
    end else if (d_req) begin
      winner = OWN_DATA;
    end

    // Reset gates the bus combinationally so read/write drop without a clock.
    if (!reset)                  cur = OWN_NONE;
    else if (owner_q != OWN_NONE) cur = owner_q;
    else                         cur = winner;

    active = ((cur == OWN_FETCH) && i_req) || ((cur == OWN_DATA) && d_req);
    done   = active && !waitrequest;

    address    = 32'h0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'h0;
    byteenable = 4'h0;
    case (cur)
      OWN_FETCH: begin
        address    = i_address;
        read       = i_read;
        byteenable = 4'b1111;
      end
      OWN_DATA: begin
        address    = d_address;
        read       = d_read & ~d_write;
        write      = d_write;
        writedata  = d_writedata;
        byteenable = d_byteenable;
      end
      default: ;
    endcase

    i_waitrequest = !((cur == OWN_FETCH) && done);
    d_waitrequest = !((cur == OWN_DATA) && done);
    i_readdata    = (cur == OWN_FETCH) ? readdata : 32'h0;
    d_readdata    = (cur == OWN_DATA)  ? readdata : 32'h0;
    grant         = cur;
    protocol_err  = perr_q;
    timeout       = tout_q;

    owner_d = owner_q;
    last_d  = last_q;
    if (!active) begin
      owner_d = OWN_NONE;
    end else if (done) begin
      owner_d = OWN_NONE;
      last_d  = cur;
    end else begin
      owner_d = cur;
    end

    perr_d = perr_q
           | ((owner_q != OWN_NONE) && !active)
           | (active && (cur == OWN_DATA) && d_read && d_write);

    stall_d = '0;
    tout_d  = tout_q;
    if (active && waitrequest && (TIMEOUT_CYCLES != 0)) begin
      stall_d = (stall_q == TMAX) ? stall_q : stall_q + 1'b1;
      if (stall_d == TMAX) tout_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// tb/tb_mips_avalon_arbiter.sv - directed self-checking bench for mips_avalon_arbiter.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write, waitrequest;
  logic [31:0] i_address, d_address, d_writedata, readdata;
  logic [3:0]  d_byteenable;

  logic        i_waitrequest, d_waitrequest, read, write, protocol_err, timeout;
  logic [31:0] i_readdata, d_readdata, address, writedata;
  logic [3:0]  byteenable;
  logic [1:0]  grant;

  logic        fp_i_wr, fp_d_wr, fp_read, fp_write, fp_perr, fp_tout;
  logic [31:0] fp_i_rd, fp_d_rd, fp_addr, fp_wdata;
  logic [3:0]  fp_be;
  logic [1:0]  fp_grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant),
    .protocol_err(protocol_err), .timeout(timeout)
  );

  mips_avalon_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(fp_i_wr), .i_readdata(fp_i_rd),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(fp_d_wr), .d_readdata(fp_d_rd),
    .address(fp_addr), .read(fp_read), .write(fp_write), .writedata(fp_wdata), .byteenable(fp_be),
    .waitrequest(waitrequest), .readdata(readdata), .grant(fp_grant),
    .protocol_err(fp_perr), .timeout(fp_tout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; waitrequest = 0;
    i_address = 0; d_address = 0; d_writedata = 0; d_byteenable = 0; readdata = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 0;
    #1;
    reset = 1;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    step();
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_grant", grant, 0);
    check("rst_i_wait", i_waitrequest, 1);
    check("rst_d_wait", d_waitrequest, 1);
    check("rst_perr", protocol_err, 0);
    check("rst_tout", timeout, 0);
    reset = 1;

    // Single fetch, zero latency
    step();
    i_read = 1; i_address = 32'hBFC00000; readdata = 32'h24020005;
    #1;
    check("fetch_read", read, 1);
    check("fetch_addr", address, 32'hBFC00000);
    check("fetch_be", byteenable, 4'hF);
    check("fetch_i_wait", i_waitrequest, 0);
    check("fetch_i_rdata", i_readdata, 32'h24020005);
    check("fetch_d_rdata", d_readdata, 0);
    check("fetch_grant", grant, 2'b01);

    // Round-robin contention, plus fixed-priority instance on the same inputs
    step();
    pulse_reset();
    i_read = 1; d_read = 1; d_address = 32'h00000040; readdata = 32'h11223344;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_i_wait", i_waitrequest, (k % 2 == 0) ? 0 : 1);
      check("rr_d_wait", d_waitrequest, (k % 2 == 0) ? 1 : 0);
      check("fp_grant", fp_grant, 2'b10);
      check("fp_i_wait", fp_i_wr, 1);
      step();
    end

    // Locked stall: write held for 4 cycles, fetch granted afterwards
    pulse_reset();
    d_write = 1; d_address = 32'h00001000; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    waitrequest = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) i_read = 1;
      if (k == 3) waitrequest = 0;
      i_address = 32'h00000100;
      #1;
      check("lock_write", write, 1);
      check("lock_read", read, 0);
      check("lock_addr", address, 32'h00001000);
      check("lock_wdata", writedata, 32'hDEADBEEF);
      check("lock_be", byteenable, 4'b0011);
      check("lock_grant", grant, 2'b10);
      check("lock_i_wait", i_waitrequest, 1);
      check("lock_d_wait", d_waitrequest, (k == 3) ? 0 : 1);
      step();
    end
    d_write = 0;
    #1;
    check("post_lock_grant", grant, 2'b01);
    check("post_lock_read", read, 1);
    check("post_lock_addr", address, 32'h00000100);
    check("post_lock_i_wait", i_waitrequest, 0);
    check("post_lock_tout", timeout, 0);
    check("post_lock_perr", protocol_err, 0);

    // Read and write together: forwarded as a write, flagged
    step();
    pulse_reset();
    d_read = 1; d_write = 1; d_address = 32'h20;
    #1;
    check("rw_write", write, 1);
    check("rw_read", read, 0);
    step();
    check("rw_perr", protocol_err, 1);

    // Owner drops its request while locked
    pulse_reset();
    check("drop_perr_cleared", protocol_err, 0);
    d_read = 1; d_address = 32'h30; waitrequest = 1;
    step();
    d_read = 0;
    #1;
    check("drop_read", read, 0);
    check("drop_write", write, 0);
    check("drop_grant_locked", grant, 2'b10);
    check("drop_d_wait", d_waitrequest, 1);
    step();
    check("drop_grant_none", grant, 2'b00);
    check("drop_perr", protocol_err, 1);

    // Timeout after 8 stalled cycles, then asynchronous reset
    pulse_reset();
    i_read = 1; i_address = 32'h80; waitrequest = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("tout_flag", timeout, (k == 8) ? 1 : 0);
    end
    check("tout_read_held", read, 1);
    check("tout_grant_held", grant, 2'b01);
    step();
    check("tout_sticky", timeout, 1);
    #1;
    reset = 0;
    #1;
    check("async_rst_read", read, 0);
    check("async_rst_grant", grant, 2'b00);
    check("async_rst_tout", timeout, 0);
    check("async_rst_i_wait", i_waitrequest, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
